// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, load size encodings and types for the register-file writer
package wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int GP_REG_COUNT = 32;
  localparam int RA_W = $clog2(GP_REG_COUNT);
  localparam logic [1:0] LD_SIZE_B = 2'b00;
  localparam logic [1:0] LD_SIZE_H = 2'b01;
  localparam logic [1:0] LD_SIZE_W = 2'b10;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [1:0]      size;
    logic            uns;
    logic [1:0]      off;
  } ld_req_t;
endpackage

// File: rtl/wb_arbiter_load_formatter.sv
// load_formatter: selects the byte/halfword lane of a memory word and sign/zero extends it
module load_formatter
  import wb_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = rdata[{offset[1], 4'b0000} +: 16];
    data = size[1] ? rdata
         : size[0] ? {{(XLEN-16){~uns & h[15]}}, h}
         : {{(XLEN-8){~uns & b[7]}}, b};
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and load responses into the single register-file write port
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid_i,
  input  logic [RA_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ready_o,
  input  logic            ld_req_valid_i,
  input  logic [RA_W-1:0] ld_req_rd_i,
  input  logic [1:0]      ld_req_size_i,
  input  logic            ld_req_unsigned_i,
  input  logic [1:0]      ld_req_offset_i,
  output logic            ld_req_ready_o,
  input  logic            ld_rvalid_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic            pend_valid_o,
  output logic [RA_W-1:0] pend_rd_o,
  output logic            rf_we_o,
  output logic [RA_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            spurious_rsp_o
);
  state_t          state, state_n;
  ld_req_t         ld;
  logic            up;
  logic            skid_valid;
  logic [RA_W-1:0] skid_rd;
  logic [XLEN-1:0] skid_data;
  logic [XLEN-1:0] ld_data;
  logic            ld_win, alu_acc, ld_acc, win_valid;
  logic [RA_W-1:0] win_rd;
  logic [XLEN-1:0] win_data;

  load_formatter u_fmt (
    .rdata  (ld_rdata_i),
    .size   (ld.size),
    .uns    (ld.uns),
    .offset (ld.off),
    .data   (ld_data)
  );

  // up keeps both ready outputs low while reset is asserted
  assign alu_ready_o    = up & ~skid_valid;
  assign ld_req_ready_o = up & (state == ST_IDLE);
  assign pend_valid_o   = state == ST_WAIT;
  assign pend_rd_o      = ld.rd;

  always_comb begin
    ld_win    = pend_valid_o & ld_rvalid_i;
    alu_acc   = alu_valid_i & alu_ready_o;
    ld_acc    = ld_req_valid_i & ld_req_ready_o;
    win_valid = ld_win | skid_valid | alu_acc;
    win_rd    = ld_win ? ld.rd : skid_valid ? skid_rd : alu_rd_i;
    win_data  = ld_win ? ld_data : skid_valid ? skid_data : alu_data_i;
    state_n   = ld_acc ? ST_WAIT : ld_win ? ST_IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ld             <= '0;
      up             <= 1'b0;
      skid_valid     <= 1'b0;
      skid_rd        <= '0;
      skid_data      <= '0;
      rf_we_o        <= 1'b0;
      rf_waddr_o     <= '0;
      rf_wdata_o     <= '0;
      spurious_rsp_o <= 1'b0;
    end else begin
      state <= state_n;
      up    <= 1'b1;
      if (ld_acc) ld <= '{rd: ld_req_rd_i, size: ld_req_size_i, uns: ld_req_unsigned_i, off: ld_req_offset_i};
      // a skid entry survives only while a load response keeps beating it
      skid_valid <= ld_win & (skid_valid | alu_acc);
      if (ld_win & alu_acc) begin
        skid_rd   <= alu_rd_i;
        skid_data <= alu_data_i;
      end
      rf_we_o        <= win_valid & (|win_rd);
      rf_waddr_o     <= win_rd;
      rf_wdata_o     <= win_data;
      spurious_rsp_o <= ld_rvalid_i & ~pend_valid_o;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_req_valid = 1'b0;
  logic [4:0]  ld_req_rd = '0;
  logic [1:0]  ld_req_size = '0;
  logic        ld_req_unsigned = 1'b0;
  logic [1:0]  ld_req_offset = '0;
  logic        ld_req_ready;
  logic        ld_rvalid = 1'b0;
  logic [31:0] ld_rdata = '0;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        spurious;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .alu_valid_i       (alu_valid),
    .alu_rd_i          (alu_rd),
    .alu_data_i        (alu_data),
    .alu_ready_o       (alu_ready),
    .ld_req_valid_i    (ld_req_valid),
    .ld_req_rd_i       (ld_req_rd),
    .ld_req_size_i     (ld_req_size),
    .ld_req_unsigned_i (ld_req_unsigned),
    .ld_req_offset_i   (ld_req_offset),
    .ld_req_ready_o    (ld_req_ready),
    .ld_rvalid_i       (ld_rvalid),
    .ld_rdata_i        (ld_rdata),
    .pend_valid_o      (pend_valid),
    .pend_rd_o         (pend_rd),
    .rf_we_o           (rf_we),
    .rf_waddr_o        (rf_waddr),
    .rf_wdata_o        (rf_wdata),
    .spurious_rsp_o    (spurious)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  // reference model state: one optional outstanding load, FIFO of deferred ALU writes
  bit          m_up, m_pend, m_uns;
  logic [4:0]  m_rd;
  logic [1:0]  m_size, m_off;
  wr_t         skq[$];
  logic        e_we, e_spur;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  function automatic logic [31:0] fmt(logic [31:0] rdata, logic [1:0] size, logic uns, logic [1:0] off);
    int w, sh;
    logic [63:0] v, mask;
    if (size == 2'd0) begin w = 8; sh = 8 * off; end
    else if (size == 2'd1) begin w = 16; sh = 16 * (off / 2); end
    else begin w = 32; sh = 0; end
    mask = (64'd1 << w) - 64'd1;
    v = ({32'd0, rdata} >> sh) & mask;
    if (!uns && w < 32 && v[w-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic clear_inputs();
    alu_valid = 0; ld_req_valid = 0; ld_rvalid = 0;
    alu_rd = 0; alu_data = 0; ld_req_rd = 0; ld_req_size = 0;
    ld_req_unsigned = 0; ld_req_offset = 0; ld_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_up = 0; m_pend = 0; m_rd = 0; m_size = 0; m_off = 0; m_uns = 0;
    skq.delete();
  endtask

  // one clock with the current inputs; leaves the expected rf/spurious outputs in e_*
  task automatic step();
    bit ldw, got, ardy, lrdy;
    wr_t nw;
    ardy = m_up && skq.size() == 0;
    lrdy = m_up && !m_pend;
    ldw = m_pend && ld_rvalid;
    e_spur = !m_pend && ld_rvalid;
    if (alu_valid && ardy) skq.push_back('{alu_rd, alu_data});
    got = 0;
    if (ldw) begin
      e_waddr = m_rd; e_wdata = fmt(ld_rdata, m_size, m_uns, m_off); got = 1;
    end else if (skq.size() > 0) begin
      nw = skq.pop_front(); e_waddr = nw.rd; e_wdata = nw.d; got = 1;
    end
    e_we = got && e_waddr != 0;
    if (ldw) m_pend = 0;
    else if (ld_req_valid && lrdy) begin
      m_pend = 1; m_rd = ld_req_rd; m_size = ld_req_size; m_uns = ld_req_unsigned; m_off = ld_req_offset;
    end
    m_up = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, spurious, alu_ready, ld_req_ready, pend_valid, pend_rd} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0",
        {rf_we, rf_waddr, rf_wdata, spurious, alu_ready, ld_req_ready, pend_valid, pend_rd});
    end
    do_reset();
    step();
    checks++;
    if ({alu_ready, ld_req_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b exp 11", {alu_ready, ld_req_ready});
    end
  endtask

  task automatic test_alu();
    do_reset(); step();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    step();
    clear_inputs();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL alu_write: got %b/%0d/%h exp 1/5/00001234", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b exp 1", alu_ready); end
    step();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_idle_we: got %b exp 0", rf_we); end
  endtask

  task automatic test_signed_byte();
    do_reset(); step();
    ld_req_valid = 1; ld_req_rd = 7; ld_req_size = 2'b00; ld_req_unsigned = 0; ld_req_offset = 2;
    step();
    clear_inputs();
    checks++;
    if ({pend_valid, pend_rd, ld_req_ready} !== {1'b1, 5'd7, 1'b0}) begin
      errors++; $display("FAIL sb_pend: got %b/%0d/%b exp 1/7/0", pend_valid, pend_rd, ld_req_ready);
    end
    step();
    ld_rvalid = 1; ld_rdata = 32'h0080_0000;
    checks++;
    if (pend_valid !== 1'b1) begin errors++; $display("FAIL sb_pend_rsp: got %b exp 1", pend_valid); end
    step();
    clear_inputs();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL sb_write: got %b/%0d/%h exp 1/7/ffffff80", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (pend_valid !== 1'b0) begin errors++; $display("FAIL sb_pend_clear: got %b exp 0", pend_valid); end
  endtask

  task automatic test_unsigned_half();
    do_reset(); step();
    ld_req_valid = 1; ld_req_rd = 9; ld_req_size = 2'b01; ld_req_unsigned = 1; ld_req_offset = 3;
    step();
    clear_inputs();
    ld_rvalid = 1; ld_rdata = 32'h9ABC_0000;
    step();
    clear_inputs();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h0000_9ABC}) begin
      errors++; $display("FAIL uh_write: got %b/%0d/%h exp 1/9/00009abc", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_collision();
    do_reset(); step();
    ld_req_valid = 1; ld_req_rd = 3; ld_req_size = 2'b10;
    step();
    clear_inputs();
    ld_rvalid = 1; ld_rdata = 32'h1122_3344;
    alu_valid = 1; alu_rd = 4; alu_data = 32'hAA;
    step();
    clear_inputs();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h1122_3344}) begin
      errors++; $display("FAIL col_load: got %b/%0d/%h exp 1/3/11223344", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (alu_ready !== 1'b0) begin errors++; $display("FAIL col_skid_ready: got %b exp 0", alu_ready); end
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hAA}) begin
      errors++; $display("FAIL col_skid: got %b/%0d/%h exp 1/4/000000aa", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (alu_ready !== 1'b1) begin errors++; $display("FAIL col_ready_back: got %b exp 1", alu_ready); end
  endtask

  task automatic test_rd0_spurious();
    do_reset(); step();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    step();
    clear_inputs();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b exp 0", rf_we); end
    ld_rvalid = 1; ld_rdata = 32'hDEAD_BEEF;
    step();
    clear_inputs();
    checks++;
    if ({spurious, rf_we} !== 2'b10) begin
      errors++; $display("FAIL spur_pulse: got %b exp 10", {spurious, rf_we});
    end
    step();
    checks++;
    if (spurious !== 1'b0) begin errors++; $display("FAIL spur_one_cycle: got %b exp 0", spurious); end
  endtask

  task automatic test_reset_in_wait();
    do_reset(); step();
    ld_req_valid = 1; ld_req_rd = 12; ld_req_size = 2'b10;
    step();
    clear_inputs();
    rst_n = 0;
    #1;
    checks++;
    if ({pend_valid, ld_req_ready} !== 2'b00) begin
      errors++; $display("FAIL rw_in_reset: got %b exp 00", {pend_valid, ld_req_ready});
    end
    do_reset(); step();
    ld_rvalid = 1; ld_rdata = 32'h1;
    checks++;
    if (ld_req_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b exp 1", ld_req_ready); end
    step();
    clear_inputs();
    checks++;
    if ({spurious, rf_we} !== 2'b10) begin
      errors++; $display("FAIL rw_spurious: got %b exp 10", {spurious, rf_we});
    end
  endtask

  task automatic test_random();
    do_reset(); step();
    for (int i = 0; i < 600; i++) begin
      alu_valid = ($urandom_range(0, 2) != 0);
      alu_rd = 5'($urandom_range(0, 31));
      alu_data = $urandom;
      ld_req_valid = ($urandom_range(0, 2) == 0);
      ld_req_rd = 5'($urandom_range(0, 31));
      ld_req_size = 2'($urandom_range(0, 3));
      ld_req_unsigned = 1'($urandom_range(0, 1));
      ld_req_offset = 2'($urandom_range(0, 3));
      ld_rvalid = ($urandom_range(0, 3) == 0);
      ld_rdata = $urandom;
      checks++;
      if ({alu_ready, ld_req_ready, pend_valid} !== {m_up && skq.size() == 0, m_up && !m_pend, m_pend}) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b exp %b", i, {alu_ready, ld_req_ready, pend_valid},
          {m_up && skq.size() == 0, m_up && !m_pend, m_pend});
      end
      if (m_pend) begin
        checks++;
        if (pend_rd !== m_rd) begin errors++; $display("FAIL rnd_pend_rd[%0d]: got %0d exp %0d", i, pend_rd, m_rd); end
      end
      step();
      checks++;
      if ({rf_we, spurious} !== {e_we, e_spur}) begin
        errors++; $display("FAIL rnd_we_spur[%0d]: got %b exp %b", i, {rf_we, spurious}, {e_we, e_spur});
      end
      if (e_we) begin
        checks++;
        if ({rf_waddr, rf_wdata} !== {e_waddr, e_wdata}) begin
          errors++; $display("FAIL rnd_write[%0d]: got %0d/%h exp %0d/%h", i, rf_waddr, rf_wdata, e_waddr, e_wdata);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_signed_byte();
    test_unsigned_half();
    test_collision();
    test_rd0_spurious();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
